// File: rtl/evm_multi_if.sv
// Ballot-unit / display-controller signal bundle for evm_multi.
// master = ballot and display side, slave = the voting machine.
interface evm_multi_if #(
   parameter int NUM_CAND = 4,
   parameter int WIDTH    = 8
);
   localparam int IW = $clog2(NUM_CAND);
   localparam int CW = $clog2(NUM_CAND + 1);

   logic                  switch_on_evm;
   logic                  candidate_ready;
   logic [NUM_CAND-1:0]   vote;
   logic                  voting_session_done;
   logic [IW-1:0]         display_sel;
   logic                  display_winner;
   logic [CW-1:0]         candidate_id;
   logic [WIDTH-1:0]      results;
   logic                  invalid_results;
   logic                  voting_in_progress;
   logic                  voting_done;
   logic                  vote_rejected;
   logic [WIDTH+IW-1:0]   total_votes;

   modport master (
      output switch_on_evm, candidate_ready, vote, voting_session_done,
             display_sel, display_winner,
      input  candidate_id, results, invalid_results, voting_in_progress,
             voting_done, vote_rejected, total_votes
   );

   modport slave (
      input  switch_on_evm, candidate_ready, vote, voting_session_done,
             display_sel, display_winner,
      output candidate_id, results, invalid_results, voting_in_progress,
             voting_done, vote_rejected, total_votes
   );
endinterface

// File: rtl/evm_multi.sv
// Parametrised electronic voting machine: saturating tallies, multi-press rejection,
// sequential winner scan. Define EVM_TIMEOUT_EN to build the idle-timeout timer.
module evm_multi #(
   parameter int NUM_CAND       = 4,
   parameter int WIDTH          = 8,
   parameter int TIMEOUT_CYCLES = 100
) (
   input  logic      clk,
   input  logic      rst,
   evm_multi_if.slave bus
);
   localparam int IW = $clog2(NUM_CAND);
   localparam int CW = $clog2(NUM_CAND + 1);
   localparam int TW = WIDTH + IW;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_WAIT_CAND = 3'd1;
   localparam logic [2:0] S_WAIT_VOTE = 3'd2;
   localparam logic [2:0] S_VOTED     = 3'd3;
   localparam logic [2:0] S_DONE      = 3'd4;

   logic [2:0]       state_q, state_d;
   logic [WIDTH-1:0] tally_q [NUM_CAND];
   logic [WIDTH-1:0] tally_d [NUM_CAND];
   logic [TW-1:0]    total_q, total_d;
   logic [IW-1:0]    vote_idx_q, vote_idx_d;
   logic [CW-1:0]    scan_idx_q, scan_idx_d;
   logic [WIDTH-1:0] max_q, max_d;
   logic [IW-1:0]    max_idx_q, max_idx_d;
   logic             tie_q, tie_d;
   logic             timeout;
   logic             vote_multi;
   logic             scan_done;
   logic [IW-1:0]    vote_enc;

   assign vote_multi = (bus.vote != '0) && !$onehot(bus.vote);

   always_comb begin
      vote_enc = '0;
      for (int i = 0; i < NUM_CAND; i++)
         if (bus.vote[i]) vote_enc = IW'(i);
   end

`ifdef EVM_TIMEOUT_EN
   localparam int TMW = $clog2(TIMEOUT_CYCLES);
   logic [TMW-1:0] timer_q, timer_d;

   // Counts only uninterrupted idle cycles; any state change restarts it from zero.
   always_comb begin
      timer_d = '0;
      if (state_d == state_q &&
          ((state_q == S_WAIT_CAND && !bus.candidate_ready) ||
           (state_q == S_WAIT_VOTE && bus.vote == '0)))
         timer_d = timer_q + TMW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst || !bus.switch_on_evm) timer_q <= '0;
      else                           timer_q <= timer_d;
   end

   assign timeout = (timer_q == TMW'(TIMEOUT_CYCLES - 1));
`else
   // TIMEOUT_CYCLES is at least 2, so this stays low: no timeout without the timer.
   assign timeout = (TIMEOUT_CYCLES < 2);
`endif

   always_comb begin
      state_d    = state_q;
      total_d    = total_q;
      vote_idx_d = vote_idx_q;
      for (int k = 0; k < NUM_CAND; k++) tally_d[k] = tally_q[k];
      scan_idx_d = '0;
      max_d      = '0;
      max_idx_d  = '0;
      tie_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.switch_on_evm) begin
               state_d = S_WAIT_CAND;
               total_d = '0;
               for (int k = 0; k < NUM_CAND; k++) tally_d[k] = '0;
            end
         end
         S_WAIT_CAND: begin
            if (bus.candidate_ready)          state_d = S_WAIT_VOTE;
            else if (bus.voting_session_done) state_d = S_DONE;
            else if (timeout)                 state_d = S_DONE;
         end
         S_WAIT_VOTE: begin
            if ($onehot(bus.vote) && !bus.candidate_ready) begin
               vote_idx_d = vote_enc;
               state_d    = S_VOTED;
            end else if (timeout) begin
               state_d = S_WAIT_CAND;
            end
         end
         S_VOTED: begin
            if (tally_q[vote_idx_q] != '1)
               tally_d[vote_idx_q] = tally_q[vote_idx_q] + WIDTH'(1);
            if (total_q != '1)
               total_d = total_q + TW'(1);
            state_d = bus.candidate_ready ? S_WAIT_VOTE : S_WAIT_CAND;
         end
         S_DONE: begin
            scan_idx_d = scan_idx_q;
            max_d      = max_q;
            max_idx_d  = max_idx_q;
            tie_d      = tie_q;
            // One tally per cycle; the scan registers sit at zero outside DONE.
            if (scan_idx_q < CW'(NUM_CAND)) begin
               if (tally_q[scan_idx_q[IW-1:0]] > max_q) begin
                  max_d     = tally_q[scan_idx_q[IW-1:0]];
                  max_idx_d = scan_idx_q[IW-1:0];
                  tie_d     = 1'b0;
               end else if (tally_q[scan_idx_q[IW-1:0]] == max_q) begin
                  tie_d = 1'b1;
               end
               scan_idx_d = scan_idx_q + CW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || !bus.switch_on_evm) begin
         state_q    <= S_IDLE;
         total_q    <= '0;
         vote_idx_q <= '0;
         scan_idx_q <= '0;
         max_q      <= '0;
         max_idx_q  <= '0;
         tie_q      <= 1'b0;
         for (int k = 0; k < NUM_CAND; k++) tally_q[k] <= '0;
      end else begin
         state_q    <= state_d;
         total_q    <= total_d;
         vote_idx_q <= vote_idx_d;
         scan_idx_q <= scan_idx_d;
         max_q      <= max_d;
         max_idx_q  <= max_idx_d;
         tie_q      <= tie_d;
         for (int k = 0; k < NUM_CAND; k++) tally_q[k] <= tally_d[k];
      end
   end

   assign scan_done = (state_q == S_DONE) && (scan_idx_q == CW'(NUM_CAND));

   always_comb begin
      bus.candidate_id    = '0;
      bus.results         = '0;
      bus.invalid_results = 1'b0;
      if (scan_done && !rst) begin
         if (tie_q) begin
            bus.invalid_results = 1'b1;
         end else if (bus.display_winner) begin
            bus.candidate_id = CW'(max_idx_q) + CW'(1);
            bus.results      = max_q;
         end else if ({1'b0, bus.display_sel} < (IW+1)'(NUM_CAND)) begin
            bus.candidate_id = CW'(bus.display_sel) + CW'(1);
            bus.results      = tally_q[bus.display_sel];
         end
      end
   end

   assign bus.voting_in_progress = !rst && (state_q == S_WAIT_VOTE);
   assign bus.voting_done        = !rst && scan_done;
   assign bus.vote_rejected      = !rst && (state_q == S_WAIT_VOTE) && vote_multi;
   assign bus.total_votes        = rst ? '0 : total_q;
endmodule
